// File: rtl/mux4_rr_arbiter.sv
// Four-input round-robin mux with a one-entry registered output stage.
// A grant may stay on one requester for up to MAX_BURST consecutive beats.
module mux4_rr_arbiter #(
   parameter int WIDTH     = 64,
   parameter int SEL_WIDTH = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req_valid,
   input  logic [WIDTH-1:0]     data0,
   input  logic [WIDTH-1:0]     data1,
   input  logic [WIDTH-1:0]     data2,
   input  logic [WIDTH-1:0]     data3,
   output logic [3:0]           req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_sel
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t               state, state_nxt;
   logic [SEL_WIDTH-1:0] cur, grant, idx;
   logic [3:0]           cnt, cnt_nxt;
   logic                 can_load, load, lock, found;
   logic [WIDTH-1:0]     dsel;

   assign out_valid = (state == FULL);
   assign can_load  = !out_valid || out_ready;
   // Gate with rst so nothing is accepted while reset discards state.
   assign load      = !rst && can_load && (req_valid != 4'b0);
   assign lock      = (cnt != 4'd0) && (cnt < 4'(MAX_BURST)) && req_valid[cur];
   assign cnt_nxt   = lock ? cnt + 4'd1 : 4'd1;
   assign req_ready = load ? (4'b0001 << grant) : 4'b0000;

   // Search order cur+1 .. cur+4 (wraps back to cur last).
   always_comb begin
      grant = cur;
      found = 1'b0;
      idx   = cur;
      for (int k = 1; k <= 4; k++) begin
         idx = cur + SEL_WIDTH'(k);
         if (!found && req_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
      if (lock) grant = cur;
   end

   always_comb begin
      dsel = data0;
      case (grant)
         2'd1:    dsel = data1;
         2'd2:    dsel = data2;
         2'd3:    dsel = data3;
         default: dsel = data0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (req_valid != 4'b0) state_nxt = FULL;
         FULL:    if (out_ready && req_valid == 4'b0) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_sel  <= '0;
         cur      <= '1;
         cnt      <= 4'd0;
      end else if (load) begin
         out_data <= dsel;
         out_sel  <= grant;
         cur      <= grant;
         cnt      <= cnt_nxt;
      end else if (can_load) begin
         cnt      <= 4'd0;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: vector table plus hand sequences, beats tracked
// through a scoreboard queue; a second instance runs with MAX_BURST=1.
module tb_mux4_rr_arbiter;
   localparam int W = 64;

   typedef struct {
      logic       rst;
      logic [3:0] rv;
      logic       ordy;
      logic [3:0] exp_rdy;
   } vec_t;

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, out_ready, out_valid;
   logic [3:0]   req_valid, req_ready;
   logic [W-1:0] d [4];
   logic [W-1:0] out_data;
   logic [1:0]   out_sel;

   logic         rst1, ordy1, ov1;
   logic [3:0]   rv1, rdy1;
   logic [W-1:0] od1;
   logic [1:0]   os1;

   mux4_rr_arbiter #(.WIDTH(W), .SEL_WIDTH(2), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sel(out_sel));

   mux4_rr_arbiter #(.WIDTH(W), .SEL_WIDTH(2), .MAX_BURST(1)) dut1 (
      .clk(clk), .rst(rst1), .req_valid(rv1),
      .data0(d[0]), .data1(d[1]), .data2(d[2]), .data3(d[3]),
      .req_ready(rdy1), .out_valid(ov1), .out_ready(ordy1),
      .out_data(od1), .out_sel(os1));

   vec_t        tbl[$];
   beat_t       sbq[$];
   int          checks = 0;
   int          errors = 0;
   logic        mov    = 1'b0;
   logic [15:0] dtag   = 16'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] enc(input logic [3:0] r);
      enc = 2'd0;
      for (int i = 0; i < 4; i++) if (r[i]) enc = 2'(i);
   endfunction

   function automatic void add(input logic r, input logic [3:0] rv, input logic o, input logic [3:0] e);
      tbl.push_back(vec_t'{r, rv, o, e});
   endfunction

   // One cycle: drive at negedge, check mid-cycle, update model at posedge.
   task automatic run(input vec_t v);
      beat_t b;
      rst       = v.rst;
      req_valid = v.rv;
      out_ready = v.ordy;
      for (int i = 0; i < 4; i++) d[i] = {32'hDEAD_BEEF, dtag, 16'(i)};
      #1;
      chk("req_ready", 64'(req_ready), 64'(v.exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(mov));
      if (out_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard actual=beat_out required=no_beat t=%0t", $time);
         end else begin
            chk("out_sel", 64'(out_sel), 64'(sbq[0].sel));
            chk("out_data", out_data, sbq[0].data);
            if (v.ordy || v.rst) void'(sbq.pop_front());
         end
      end
      if (!v.rst && v.exp_rdy != 4'b0) begin
         b.sel  = enc(v.exp_rdy);
         b.data = d[b.sel];
         sbq.push_back(b);
      end
      @(posedge clk);
      if (v.rst)               mov = 1'b0;
      else if (!mov || v.ordy) mov = |v.rv;
      dtag++;
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic [3:0] rv, input logic o, input logic [3:0] e);
      run(vec_t'{r, rv, o, e});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rst1 = 1'b1; req_valid = 4'hF; rv1 = 4'h0;
      out_ready = 1'b1; ordy1 = 1'b1;
      for (int i = 0; i < 4; i++) d[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst1 = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_sel", 64'(out_sel), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);

      // All requesting, burst of 4 then rotate; then single requester, no bubbles.
      add(1'b1, 4'hF, 1'b1, 4'b0000);
      for (int i = 0; i < 4; i++) add(1'b0, 4'hF, 1'b1, 4'b0001);
      for (int i = 0; i < 4; i++) add(1'b0, 4'hF, 1'b1, 4'b0010);
      add(1'b0, 4'h0, 1'b1, 4'b0000);
      for (int i = 0; i < 10; i++) add(1'b0, 4'b0010, 1'b1, 4'b0010);
      add(1'b0, 4'h0, 1'b1, 4'b0000);
      foreach (tbl[i]) run(tbl[i]);

      // Backpressure while FULL holding data2; release loads the next beat at once.
      dtag = 16'd0;
      step(1'b0, 4'b0100, 1'b1, 4'b0100);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 4'hF, 1'b0, 4'b0000);
         chk("hold_data", out_data, 64'hDEAD_BEEF_0000_0002);
         chk("hold_sel", 64'(out_sel), 64'd2);
      end
      step(1'b0, 4'hF, 1'b1, 4'b0100);
      step(1'b0, 4'h0, 1'b1, 4'b0000);

      // Requester 0 locked at cnt=2 drops out; 2 takes over with a fresh count.
      step(1'b0, 4'b0101, 1'b1, 4'b0001);
      step(1'b0, 4'b0101, 1'b1, 4'b0001);
      step(1'b0, 4'b0100, 1'b1, 4'b0100);
      step(1'b0, 4'b0101, 1'b1, 4'b0100);
      step(1'b0, 4'b0101, 1'b1, 4'b0100);
      step(1'b0, 4'b0101, 1'b1, 4'b0100);
      step(1'b0, 4'b0101, 1'b1, 4'b0001);

      // Reset while FULL discards the beat; first grant afterwards is 0.
      step(1'b0, 4'b1000, 1'b1, 4'b1000);
      step(1'b1, 4'hF, 1'b0, 4'b0000);
      chk("rst_full_data", out_data, 64'd0);
      chk("rst_full_sel", 64'(out_sel), 64'd0);
      step(1'b0, 4'hF, 1'b1, 4'b0001);
      step(1'b0, 4'h0, 1'b1, 4'b0000);
      chk("sb_drained", 64'(sbq.size()), 64'd0);

      // MAX_BURST=1 instance alternates between requesters 1 and 3.
      rst1 = 1'b1; rv1 = 4'h0; ordy1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst1 = 1'b0; rv1 = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("mb1_ready", 64'(rdy1), (i % 2 == 1) ? 64'h8 : 64'h2);
         if (i > 0) begin
            chk("mb1_sel", 64'(os1), (i % 2 == 1) ? 64'd1 : 64'd3);
            chk("mb1_valid", 64'(ov1), 64'd1);
         end
         @(posedge clk);
         @(negedge clk);
      end
      chk("mb1_sel_last", 64'(os1), 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
